weight_feeder: RTL

//  Read side of the binary-weight path: fetches packed 1-bit weight vectors from weight RAM and streams them
//  as weight_bits/en into parallel_mult, one vector per cycle, for one layer pass of num_out output neurons.

---
 rtl/fpga_nn_pkg.sv | 13 +
 rtl/weight_skid.sv | 37 +++
 rtl/weight_feeder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fpga_nn_pkg.sv
// Shared defaults and state encoding for the binary-weight datapath.
package fpga_nn_pkg;

  localparam int unsigned N_IN_DEFAULT   = 16;
  localparam int unsigned ADDR_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush
  } feeder_state_t;

endpackage

// File: rtl/weight_skid.sv
// One-entry skid buffer that parks a returning RAM vector while the consumer stalls.
module weight_skid #(
  parameter int unsigned Width = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full
);

  logic             full_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (push) begin
        data_q <= din;
        full_q <= 1'b1;
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end
  end

  assign dout = data_q;
  assign full = full_q;

  // A push into a full entry that is not drained in the same cycle would lose a vector.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst) !(push && full_q && !pop));

endmodule

// File: rtl/weight_feeder.sv
// Streams packed 1-bit weight vectors from weight RAM into parallel_mult for one layer pass,
// absorbing the one-cycle RAM latency and consumer hold with a single skid entry.
module weight_feeder
  import fpga_nn_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_out,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [N_IN-1:0]   mem_rdata,
  input  logic              hold,
  output logic [N_IN-1:0]   weight_bits,
  output logic              en,
  output logic [ADDR_W-1:0] row_idx,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned VecW = N_IN + ADDR_W + 1;

  feeder_state_t     state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] issued_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] pend_row_q;
  logic              pend_last_q;

  logic            issue_last;
  logic            out_free;
  logic            consume;
  logic            finish;
  logic            accept;
  logic            skid_push;
  logic            skid_pop;
  logic            skid_full;
  logic [VecW-1:0] ret_vec;
  logic [VecW-1:0] skid_vec;

  assign mem_rd_en  = busy && (issued_q != num_q) && !hold;
  assign mem_addr   = base_q + issued_q;
  assign issue_last = (issued_q + ADDR_W'(1)) == num_q;

  assign out_free = !en || !hold;
  assign consume  = en && !hold;
  assign finish   = consume && last && (state_q == StFlush);
  // A start landing on the completing edge chains straight into the next pass.
  assign accept   = start && ((state_q == StIdle) || finish);

  assign ret_vec   = {mem_rdata, pend_row_q, pend_last_q};
  assign skid_pop  = out_free && skid_full;
  assign skid_push = rd_pend_q && (!out_free || skid_full);

  weight_skid #(
    .Width(VecW)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (skid_push),
    .pop  (skid_pop),
    .din  (ret_vec),
    .dout (skid_vec),
    .full (skid_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      base_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
    end else begin
      done <= 1'b0;
      if (mem_rd_en) begin
        issued_q <= issued_q + ADDR_W'(1);
      end
      unique case (state_q)
        StIdle:   state_q <= StIdle;
        StStream: begin
          if (mem_rd_en && issue_last) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (finish) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default:  state_q <= StIdle;
      endcase
      if (accept) begin
        base_q   <= base_addr;
        num_q    <= num_out;
        issued_q <= '0;
        if (num_out != '0) begin
          state_q <= StStream;
          busy    <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

  // Tag each read with its row so the vector carries its index through the skid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q   <= 1'b0;
      pend_row_q  <= '0;
      pend_last_q <= 1'b0;
    end else begin
      rd_pend_q <= mem_rd_en;
      if (mem_rd_en) begin
        pend_row_q  <= issued_q;
        pend_last_q <= issue_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weight_bits <= '0;
      row_idx     <= '0;
      last        <= 1'b0;
      en          <= 1'b0;
    end else if (out_free) begin
      if (skid_full) begin
        {weight_bits, row_idx, last} <= skid_vec;
        en                           <= 1'b1;
      end else if (rd_pend_q) begin
        {weight_bits, row_idx, last} <= ret_vec;
        en                           <= 1'b1;
      end else begin
        en <= 1'b0;
      end
    end
  end

endmodule
